// File: rtl/sync_align.sv
// Per-channel sync delay line with blanking during delay changes, polarity
// control, rising-edge detection and an H-per-V line counter.
module sync_align #(
    parameter int CH    = 2,
    parameter int DEPTH = 32,
    parameter int DW    = $clog2(DEPTH),
    parameter int LW    = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [CH-1:0]    SYNC_IN,
    input  logic [CH*DW-1:0] DELAY,
    input  logic [CH-1:0]    POL_INV,
    output logic [CH-1:0]    SYNC_OUT,
    output logic [CH-1:0]    VALID,
    output logic [CH-1:0]    RISE_OUT,
    output logic [LW-1:0]    LINE_CNT,
    output logic [LW-1:0]    LINE_CNT_LAST
);

    typedef enum logic {FILL, RUN} state_t;

    localparam logic [DW:0]   CNT_ONE = 1;
    localparam logic [LW-1:0] LC_ONE  = 1;

    function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
        return (v == '1) ? v : v + LC_ONE;
    endfunction

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [DEPTH-1:0] sr_p0;
        logic [DW-1:0]    dly_q;
        logic [DW-1:0]    dly_live;
        state_t           state_q, state_d;
        logic [DW:0]      cnt_q, cnt_d;
        logic             chg;
        logic             sample;
        logic             sample_p1;
        logic             run;
        logic             run_p1;

        assign dly_live = DELAY[i*DW +: DW];
        assign chg      = (dly_live != dly_q);
        assign sample   = sr_p0[dly_q];
        assign run      = (state_q == RUN);

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                sr_p0     <= '0;
                dly_q     <= '0;
                state_q   <= FILL;
                cnt_q     <= '0;
                sample_p1 <= 1'b0;
                run_p1    <= 1'b0;
            end else begin
                sr_p0     <= {sr_p0[DEPTH-2:0], SYNC_IN[i]};
                dly_q     <= dly_live;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                sample_p1 <= sample;
                run_p1    <= run;
            end
        end

        // A zero count in FILL only exists right after reset; it stands for
        // a count of DELAY+1 taken from the live field in that first cycle.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (state_q == FILL && cnt_q == '0) begin
                if (dly_live == '0) begin
                    state_d = RUN;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = {1'b0, dly_live};
                end
            end else if (chg) begin
                state_d = FILL;
                cnt_d   = {1'b0, dly_live} + CNT_ONE;
            end else if (state_q == FILL) begin
                if (cnt_q == CNT_ONE) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        end

        assign VALID[i]    = run;
        assign SYNC_OUT[i] = (run & sample) ^ POL_INV[i];
        assign RISE_OUT[i] = run & run_p1 & sample & ~sample_p1;
    end

    // Line counter: H edges counted between V edges, frozen while either is blanked
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LINE_CNT      <= '0;
            LINE_CNT_LAST <= '0;
        end else if (VALID[0] && VALID[1]) begin
            if (RISE_OUT[1]) begin
                LINE_CNT_LAST <= LINE_CNT;
                LINE_CNT      <= RISE_OUT[0] ? LC_ONE : '0;
            end else if (RISE_OUT[0]) begin
                LINE_CNT <= sat_inc(LINE_CNT);
            end
        end
    end

endmodule

// File: tb/tb_sync_align.sv
// Directed bench for sync_align: delay/polarity, blanking, line counting and reset.
module tb_sync_align;
    localparam int CH    = 2;
    localparam int DEPTH = 32;
    localparam int DW    = 5;
    localparam int LW    = 12;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [CH-1:0]    SYNC_IN = '0;
    logic [CH*DW-1:0] DELAY = '0;
    logic [CH-1:0]    POL_INV = '0;
    logic [CH-1:0]    SYNC_OUT, VALID, RISE_OUT;
    logic [LW-1:0]    LINE_CNT, LINE_CNT_LAST;
    logic [CH-1:0]    s3_out, v3, r3;
    logic [2:0]       lc3, lcl3;

    int checks   = 0;
    int failures = 0;

    sync_align #(.CH(CH), .DEPTH(DEPTH), .LW(LW)) dut (
        .CLK(CLK), .RST(RST), .SYNC_IN(SYNC_IN), .DELAY(DELAY), .POL_INV(POL_INV),
        .SYNC_OUT(SYNC_OUT), .VALID(VALID), .RISE_OUT(RISE_OUT),
        .LINE_CNT(LINE_CNT), .LINE_CNT_LAST(LINE_CNT_LAST)
    );

    sync_align #(.CH(CH), .DEPTH(DEPTH), .LW(3)) dut3 (
        .CLK(CLK), .RST(RST), .SYNC_IN(SYNC_IN), .DELAY(DELAY), .POL_INV(POL_INV),
        .SYNC_OUT(s3_out), .VALID(v3), .RISE_OUT(r3),
        .LINE_CNT(lc3), .LINE_CNT_LAST(lcl3)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [1:0] pol, input logic [1:0] sin);
        RST     = 1'b1;
        SYNC_IN = sin;
        DELAY   = {d1, d0};
        POL_INV = pol;
        tick;
        tick;
        RST = 1'b0;
    endtask

    task automatic wait_valid0(input int d);
        for (int k = 0; k <= d; k++) begin
            checks++;
            if (VALID[0] !== 1'b0) begin
                failures++;
                $display("FAIL fill_valid0 d=%0d k=%0d got=%b exp=0", d, k, VALID[0]);
            end
            tick;
        end
        checks++;
        if (VALID[0] !== 1'b1) begin
            failures++;
            $display("FAIL valid0_rise d=%0d got=%b exp=1", d, VALID[0]);
        end
    endtask

    task automatic pulse(input logic h, input logic v);
        tick;
        SYNC_IN = {v, h};
        tick;
        SYNC_IN = 2'b00;
    endtask

    task automatic test_reset;
        RST     = 1'b1;
        POL_INV = 2'b10;
        tick;
        tick;
        checks++;
        if (VALID !== 2'b00 || RISE_OUT !== 2'b00 || v3 !== 2'b00 || r3 !== 2'b00) begin
            failures++;
            $display("FAIL reset_valid_rise got=%b/%b exp=00/00", VALID, RISE_OUT);
        end
        checks++;
        if (SYNC_OUT !== 2'b10 || s3_out !== 2'b10) begin
            failures++;
            $display("FAIL reset_sync_out got=%b exp=10", SYNC_OUT);
        end
        checks++;
        if (LINE_CNT !== '0 || LINE_CNT_LAST !== '0 || lc3 !== '0 || lcl3 !== '0) begin
            failures++;
            $display("FAIL reset_line_cnt got=%0d/%0d exp=0/0", LINE_CNT, LINE_CNT_LAST);
        end
    endtask

    task automatic test_pulse(input int d, input logic pol);
        logic exp_out, exp_rise;
        apply_reset(DW'(d), 5'd0, {1'b0, pol}, 2'b00);
        wait_valid0(d);
        for (int t = 0; t <= d + 26; t++) begin
            if (t > 0) tick;
            SYNC_IN[0] = (t == 20);
            #1;
            exp_rise = (t == 21 + d);
            exp_out  = exp_rise ^ pol;
            checks++;
            if (SYNC_OUT[0] !== exp_out || RISE_OUT[0] !== exp_rise) begin
                failures++;
                $display("FAIL pulse d=%0d pol=%b t=%0d got out=%b rise=%b exp out=%b rise=%b",
                         d, pol, t, SYNC_OUT[0], RISE_OUT[0], exp_out, exp_rise);
            end
        end
    endtask

    task automatic test_delay_change;
        apply_reset(5'd3, 5'd0, 2'b00, 2'b01);
        wait_valid0(3);
        checks++;
        if (RISE_OUT[0] !== 1'b0) begin
            failures++;
            $display("FAIL first_run_rise got=%b exp=0", RISE_OUT[0]);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (SYNC_OUT[0] !== 1'b1 || RISE_OUT[0] !== 1'b0) begin
                failures++;
                $display("FAIL steady_high k=%0d got out=%b rise=%b exp 1/0", k, SYNC_OUT[0], RISE_OUT[0]);
            end
        end
        POL_INV[0] = 1'b1;
        #1;
        checks++;
        if (SYNC_OUT[0] !== 1'b0 || VALID[0] !== 1'b1) begin
            failures++;
            $display("FAIL pol_toggle got out=%b valid=%b exp 0/1", SYNC_OUT[0], VALID[0]);
        end
        tick;
        checks++;
        if (VALID[0] !== 1'b1) begin
            failures++;
            $display("FAIL pol_no_blank got=%b exp=1", VALID[0]);
        end
        POL_INV[0] = 1'b0;
        tick;
        DELAY[DW-1:0] = 5'd10;
        #1;
        checks++;
        if (VALID[0] !== 1'b1) begin
            failures++;
            $display("FAIL change_cycle_valid got=%b exp=1", VALID[0]);
        end
        for (int k = 1; k <= 15; k++) begin
            tick;
            checks++;
            if (k <= 11) begin
                if (VALID[0] !== 1'b0 || SYNC_OUT[0] !== 1'b0 || RISE_OUT[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL blank k=%0d got v=%b o=%b r=%b exp 0/0/0", k, VALID[0], SYNC_OUT[0], RISE_OUT[0]);
                end
            end else begin
                if (VALID[0] !== 1'b1 || SYNC_OUT[0] !== 1'b1 || RISE_OUT[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL rerun k=%0d got v=%b o=%b r=%b exp 1/1/0", k, VALID[0], SYNC_OUT[0], RISE_OUT[0]);
                end
            end
        end
    endtask

    task automatic test_restart;
        apply_reset(5'd3, 5'd0, 2'b00, 2'b00);
        wait_valid0(3);
        tick;
        DELAY[DW-1:0] = 5'd10;
        for (int t = 1; t <= 13; t++) begin
            tick;
            if (t == 4) DELAY[DW-1:0] = 5'd6;
            #1;
            checks++;
            if (VALID[0] !== (t >= 12)) begin
                failures++;
                $display("FAIL restart t=%0d got=%b exp=%b", t, VALID[0], (t >= 12));
            end
        end
    endtask

    task automatic test_frame;
        apply_reset(5'd0, 5'd0, 2'b00, 2'b00);
        tick;
        checks++;
        if (VALID !== 2'b11) begin
            failures++;
            $display("FAIL frame_valid got=%b exp=11", VALID);
        end
        pulse(1'b0, 1'b1);
        repeat (8) pulse(1'b1, 1'b0);
        tick;
        tick;
        checks++;
        if (LINE_CNT !== 12'd8 || lc3 !== 3'd7) begin
            failures++;
            $display("FAIL lines_before_v got=%0d/%0d exp=8/7", LINE_CNT, lc3);
        end
        pulse(1'b0, 1'b1);
        tick;
        tick;
        checks++;
        if (LINE_CNT_LAST !== 12'd8 || LINE_CNT !== 12'd0 || lcl3 !== 3'd7 || lc3 !== 3'd0) begin
            failures++;
            $display("FAIL frame1 got last=%0d cnt=%0d last3=%0d cnt3=%0d exp 8/0/7/0",
                     LINE_CNT_LAST, LINE_CNT, lcl3, lc3);
        end
        repeat (8) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        tick;
        tick;
        checks++;
        if (LINE_CNT_LAST !== 12'd8 || lcl3 !== 3'd7) begin
            failures++;
            $display("FAIL frame2 got last=%0d last3=%0d exp 8/7", LINE_CNT_LAST, lcl3);
        end
        repeat (3) pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        tick;
        tick;
        checks++;
        if (LINE_CNT !== 12'd1 || LINE_CNT_LAST !== 12'd3 || lc3 !== 3'd1 || lcl3 !== 3'd3) begin
            failures++;
            $display("FAIL coincident got cnt=%0d last=%0d cnt3=%0d last3=%0d exp 1/3/1/3",
                     LINE_CNT, LINE_CNT_LAST, lc3, lcl3);
        end
        tick;
        DELAY[2*DW-1:DW] = 5'd5;
        SYNC_IN = 2'b01;
        tick;
        SYNC_IN = 2'b00;
        checks++;
        if (RISE_OUT[0] !== 1'b1 || VALID[1] !== 1'b0) begin
            failures++;
            $display("FAIL hold_setup got rise0=%b valid1=%b exp 1/0", RISE_OUT[0], VALID[1]);
        end
        tick;
        checks++;
        if (LINE_CNT !== 12'd1 || LINE_CNT_LAST !== 12'd3) begin
            failures++;
            $display("FAIL hold got cnt=%0d last=%0d exp 1/3", LINE_CNT, LINE_CNT_LAST);
        end
    endtask

    task automatic test_async_reset;
        logic [1:0] exp_v;
        POL_INV = 2'b01;
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if (VALID !== 2'b00 || RISE_OUT !== 2'b00 || SYNC_OUT !== 2'b01) begin
            failures++;
            $display("FAIL async_outputs got v=%b r=%b o=%b exp 00/00/01", VALID, RISE_OUT, SYNC_OUT);
        end
        checks++;
        if (LINE_CNT !== '0 || LINE_CNT_LAST !== '0 || lc3 !== '0 || lcl3 !== '0) begin
            failures++;
            $display("FAIL async_line_cnt got=%0d/%0d exp=0/0", LINE_CNT, LINE_CNT_LAST);
        end
        DELAY   = {5'd2, 5'd4};
        POL_INV = 2'b00;
        tick;
        RST = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            exp_v = {(k >= 3), (k >= 5)};
            checks++;
            if (VALID !== exp_v) begin
                failures++;
                $display("FAIL release_valid k=%0d got=%b exp=%b", k, VALID, exp_v);
            end
            tick;
        end
    endtask

    initial begin
        test_reset();
        test_pulse(5, 1'b0);
        test_pulse(0, 1'b0);
        test_pulse(31, 1'b0);
        test_pulse(5, 1'b1);
        test_delay_change();
        test_restart();
        test_frame();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_align.md
SYNC_ALIGN -- requirements
Module: sync_align

Interface
REQ-001 Parameter CH, default 2: number of sync channels; channel 0 = line sync (H), channel 1 = frame sync (V); CH >= 2.
REQ-002 Parameter DEPTH, default 32: maximum delay in cycles; power of two, 2..256.
REQ-003 Parameter DW, default $clog2(DEPTH): width of one delay field.
REQ-004 Parameter LW, default 12: width of the line counter.
REQ-005 CLK  in  1  the single clock; all state updates on its rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 SYNC_IN  in  CH  raw sync inputs, already synchronous to CLK.
REQ-008 DELAY  in  CH*DW  per-channel delay select; field i = DELAY[i*DW +: DW].
REQ-009 POL_INV  in  CH  per-channel output polarity inversion.
REQ-010 SYNC_OUT  out  CH  delayed, polarity-adjusted sync.
REQ-011 VALID  out  CH  channel i output is trustworthy (not blanked).
REQ-012 RISE_OUT  out  CH  one-cycle pulse on a valid rising edge of SYNC_OUT[i].
REQ-013 LINE_CNT  out  LW  rising edges of channel 0 since the last channel-1 rising edge.
REQ-014 LINE_CNT_LAST  out  LW  LINE_CNT value captured at each channel-1 rising edge.

Function
REQ-015 Each channel SHALL keep a DEPTH-bit shift register that shifts SYNC_IN[i] in every cycle, including during blanking.
REQ-016 With field d = DELAY_i stable, SYNC_OUT[i] at cycle t SHALL equal SYNC_IN[i] at cycle t-(d+1) XOR POL_INV[i]; latency range 1..DEPTH cycles.
REQ-017 POL_INV SHALL act combinationally on the output stage only; toggling it SHALL NOT blank the channel.
REQ-018 Each channel SHALL register its delay field; a difference between the live and registered field in any cycle SHALL count as a delay change.
REQ-019 Per-channel blanking state machine, states FILL and RUN: a delay change in any state moves to FILL and loads a counter with new_d+1.
REQ-020 In FILL the counter decrements once per cycle; the transition to RUN occurs in the cycle after the counter reaches 1.
REQ-021 In FILL, SYNC_OUT[i] SHALL be driven to POL_INV[i] (inactive level), VALID[i] = 0 and RISE_OUT[i] = 0.
REQ-022 In RUN, VALID[i] = 1; a delay change while already in FILL SHALL restart the count using the newest value.
REQ-023 RISE_OUT[i] SHALL be 1 for exactly one cycle when the pre-polarity delayed sample goes 0->1 and the channel was in RUN in both the current and the previous cycle.
REQ-024 The first RUN cycle after FILL SHALL NOT produce RISE_OUT, even if the delayed sample is 1.
REQ-025 LINE_CNT SHALL increment by 1 on each RISE_OUT[0], saturating at 2^LW-1.
REQ-026 On RISE_OUT[1], LINE_CNT_LAST SHALL load LINE_CNT; LINE_CNT SHALL then load 0.
REQ-027 If RISE_OUT[1] and RISE_OUT[0] occur in the same cycle, LINE_CNT_LAST SHALL load LINE_CNT and LINE_CNT SHALL load 1.
REQ-028 When VALID[0] or VALID[1] is 0, LINE_CNT and LINE_CNT_LAST SHALL hold their values.
REQ-029 A delay field of 0 SHALL be legal, giving 1-cycle latency; all values up to DEPTH-1 SHALL be legal, with no wrap.

Reset
REQ-030 While RST = 1, the following SHALL all be 0: shift registers, registered delays, SYNC_OUT (before polarity), VALID, RISE_OUT, LINE_CNT and LINE_CNT_LAST.
REQ-031 During reset, SYNC_OUT[i] SHALL equal POL_INV[i].
REQ-032 On RST release, every channel SHALL enter FILL with count DELAY_i+1, so VALID[i] rises DELAY_i+1 cycles after release.
REQ-033 Assertion of RST mid-operation SHALL immediately clear all state without waiting for a clock edge.

Verification
REQ-034 DELAY0 = 5, POL_INV = 0, single-cycle pulse on SYNC_IN[0] at cycle 20 after VALID -> SYNC_OUT[0] high at cycle 26 only; RISE_OUT[0] at cycle 26.
REQ-035 DELAY0 = 0 and DELAY0 = 31, same pulse -> output delayed by 1 and 32 cycles respectively; POL_INV[0] = 1 inverts SYNC_OUT only, with RISE_OUT timing unchanged.
REQ-036 Change DELAY0 from 3 to 10 while SYNC_IN[0] = 1 constantly -> VALID[0] low for exactly 11 cycles, SYNC_OUT[0] = 0 throughout, and no RISE_OUT[0] on return to RUN.
REQ-037 Change the delay at cycle 0 and again at cycle 4 -> FILL restarts at cycle 4; VALID timing follows the second value.
REQ-038 Frame stimulus of 8 H pulses per V pulse, including a coincident H and V pulse -> LINE_CNT_LAST = 8 on normal frames; LINE_CNT = 1 after the coincident pulse; saturation checked with LW = 3.
REQ-039 Assert RST asynchronously mid-frame -> all outputs cleared within the same cycle; after release, VALID rises per REQ-032.
